order_risk_gate: RTL and testbench

Pre-trade risk gate sitting directly upstream of `dm_cache_fsm_upstream`: it accepts one order or limit-update command at a time, reads the client's risk word through the cache CPU port, checks the order against the client limit, and writes back the accumulation when the order is accepted. The risk word is `[31:16]` max-to-trade and `[15:0]` accumulated quantity. One decision is produced per command, with a reason code, on a valid/ready output.

---
 rtl/cache_def.sv | 35 +++
 rtl/order_risk_gate_timer.sv | 34 +++
 rtl/order_risk_gate.sv | 235 +++++++++++++++++++++++
 tb/tb_order_risk_gate.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// rtl/cache_def.sv - cache CPU-port types plus risk-gate reason codes and limits
package cache_def;

    typedef struct packed {
        logic [31:0] rdindex;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef enum logic [2:0] {
        RSN_OK         = 3'd0,
        RSN_OVER_LIMIT = 3'd1,
        RSN_ZERO_QTY   = 3'd2,
        RSN_BAD_LIMIT  = 3'd3,
        RSN_TIMEOUT    = 3'd4
    } risk_reason_type;

    // The cache treats a max field of 0 or 1 as an accumulate write.
    localparam logic [15:0] RISK_MIN_LIMIT = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_CHECK,
        ST_WR_REQ,
        ST_RESP
    } gate_state_type;

endpackage

// File: rtl/order_risk_gate_timer.sv
// rtl/order_risk_gate_timer.sv - risk_gate_timer: loadable down-counter raising expired at zero
module risk_gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/order_risk_gate.sv
// rtl/order_risk_gate.sv - pre-trade risk gate in front of the cache CPU port
// Optional stats counters are enabled with RISK_GATE_STATS_EN.
module order_risk_gate
    import cache_def::*;
#(
    parameter int CLIENT_W = 6,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_op,
    input  logic [CLIENT_W-1:0] in_client,
    input  logic [15:0]         in_value,
    output cpu_req_type         cpu_req,
    input  cpu_result_type      cpu_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_accept,
    output logic [2:0]          out_reason,
    output logic [CLIENT_W-1:0] out_client,
    output logic [15:0]         out_accum
`ifdef RISK_GATE_STATS_EN
    ,
    output logic [31:0]         stat_accept,
    output logic [31:0]         stat_reject,
    output logic [31:0]         stat_timeout
`endif
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

    gate_state_type     state_q, state_d;
    logic               op_q, op_d;
    logic [CLIENT_W-1:0] client_q, client_d;
    logic [15:0]        value_q, value_d;
    logic [31:0]        rd_word_q, rd_word_d;
    cpu_req_type        req_q, req_d;
    logic               out_valid_q, out_valid_d;
    logic               accept_q, accept_d;
    risk_reason_type    reason_q, reason_d;
    logic [CLIENT_W-1:0] oclient_q, oclient_d;
    logic [15:0]        oaccum_q, oaccum_d;
    logic [16:0]        sum;
    logic               tmr_load, tmr_en, tmr_expired;

    risk_gate_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TLOAD),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        client_d    = client_q;
        value_d     = value_q;
        rd_word_d   = rd_word_q;
        req_d       = req_q;
        out_valid_d = out_valid_q;
        accept_d    = accept_q;
        reason_d    = reason_q;
        oclient_d   = oclient_q;
        oaccum_d    = oaccum_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        sum         = {1'b0, rd_word_q[15:0]} + {1'b0, value_q};
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d          = in_op;
                    client_d      = in_client;
                    value_d       = in_value;
                    oclient_d     = in_client;
                    req_d.rdindex = 32'({in_client, 4'b0000});
                    if (in_op && (in_value < RISK_MIN_LIMIT)) begin
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        accept_d    = 1'b0;
                        reason_d    = RSN_BAD_LIMIT;
                        oaccum_d    = '0;
                    end else if (in_op) begin
                        state_d     = ST_WR_REQ;
                        req_d.data  = {in_value, 16'h0};
                        req_d.rw    = 1'b1;
                        req_d.valid = 1'b1;
                        tmr_load    = 1'b1;
                    end else if (in_value == '0) begin
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        accept_d    = 1'b0;
                        reason_d    = RSN_ZERO_QTY;
                        oaccum_d    = '0;
                    end else begin
                        state_d     = ST_RD_REQ;
                        req_d.data  = '0;
                        req_d.rw    = 1'b0;
                        req_d.valid = 1'b1;
                        tmr_load    = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (cpu_res.ready) begin
                    rd_word_d   = cpu_res.data;
                    req_d.valid = 1'b0;
                    state_d     = ST_CHECK;
                end else if (tmr_expired) begin
                    req_d.valid = 1'b0;
                    state_d     = ST_RESP;
                    out_valid_d = 1'b1;
                    accept_d    = 1'b0;
                    reason_d    = RSN_TIMEOUT;
                    oaccum_d    = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_CHECK: begin
                if (sum <= {1'b0, rd_word_q[31:16]}) begin
                    state_d     = ST_WR_REQ;
                    req_d.data  = {16'h0, value_q};
                    req_d.rw    = 1'b1;
                    req_d.valid = 1'b1;
                    tmr_load    = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                    out_valid_d = 1'b1;
                    accept_d    = 1'b0;
                    reason_d    = RSN_OVER_LIMIT;
                    oaccum_d    = rd_word_q[15:0];
                end
            end
            ST_WR_REQ: begin
                // A write timeout leaves whatever the cache already did in place.
                if (cpu_res.ready || tmr_expired) begin
                    req_d.valid = 1'b0;
                    state_d     = ST_RESP;
                    out_valid_d = 1'b1;
                    accept_d    = cpu_res.ready;
                    reason_d    = cpu_res.ready ? RSN_OK : RSN_TIMEOUT;
                    oaccum_d    = op_q ? 16'h0 : (cpu_res.ready ? sum[15:0] : rd_word_q[15:0]);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            client_q    <= '0;
            value_q     <= '0;
            rd_word_q   <= '0;
            req_q       <= '0;
            out_valid_q <= 1'b0;
            accept_q    <= 1'b0;
            reason_q    <= RSN_OK;
            oclient_q   <= '0;
            oaccum_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            client_q    <= client_d;
            value_q     <= value_d;
            rd_word_q   <= rd_word_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            accept_q    <= accept_d;
            reason_q    <= reason_d;
            oclient_q   <= oclient_d;
            oaccum_q    <= oaccum_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign cpu_req    = req_q;
    assign out_valid  = out_valid_q;
    assign out_accept = accept_q;
    assign out_reason = reason_q;
    assign out_client = oclient_q;
    assign out_accum  = oaccum_q;

`ifdef RISK_GATE_STATS_EN
    logic [31:0] st_acc_q, st_acc_d, st_rej_q, st_rej_d, st_to_q, st_to_d;
    logic        hs;

    always_comb begin
        st_acc_d = st_acc_q;
        st_rej_d = st_rej_q;
        st_to_d  = st_to_q;
        hs       = (state_q == ST_RESP) && out_ready;
        if (hs) begin
            if (accept_q) begin
                if (st_acc_q != '1) st_acc_d = st_acc_q + 32'd1;
            end else if (reason_q == RSN_TIMEOUT) begin
                if (st_to_q != '1) st_to_d = st_to_q + 32'd1;
            end else begin
                if (st_rej_q != '1) st_rej_d = st_rej_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_acc_q <= '0;
            st_rej_q <= '0;
            st_to_q  <= '0;
        end else begin
            st_acc_q <= st_acc_d;
            st_rej_q <= st_rej_d;
            st_to_q  <= st_to_d;
        end
    end

    assign stat_accept  = st_acc_q;
    assign stat_reject  = st_rej_q;
    assign stat_timeout = st_to_q;
`endif

endmodule

// File: tb/tb_order_risk_gate.sv
// tb/tb_order_risk_gate.sv - directed self-checking bench for order_risk_gate with a small cache model
module tb_order_risk_gate;
    import cache_def::*;

    localparam int CLIENT_W = 6;
    localparam int TIMEOUT  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic                in_op;
    logic [CLIENT_W-1:0] in_client;
    logic [15:0]         in_value;
    cpu_req_type         cpu_req;
    cpu_result_type      cpu_res;
    logic                out_valid;
    logic                out_ready;
    logic                out_accept;
    logic [2:0]          out_reason;
    logic [CLIENT_W-1:0] out_client;
    logic [15:0]         out_accum;
`ifdef RISK_GATE_STATS_EN
    logic [31:0]         stat_accept, stat_reject, stat_timeout;
`endif

    int errors = 0;
    int checks = 0;
    int lat;
    int vc_before;

    always #5 clk = ~clk;

    order_risk_gate #(.CLIENT_W(CLIENT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_client  (in_client),
        .in_value   (in_value),
        .cpu_req    (cpu_req),
        .cpu_res    (cpu_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_accept (out_accept),
        .out_reason (out_reason),
        .out_client (out_client),
        .out_accum  (out_accum)
`ifdef RISK_GATE_STATS_EN
        ,
        .stat_accept  (stat_accept),
        .stat_reject  (stat_reject),
        .stat_timeout (stat_timeout)
`endif
    );

    // Cache model: one wait cycle then a one-cycle ready pulse; max field <= 1 accumulates.
    logic [31:0] mem [64];
    logic        pending;
    logic        res_ready;
    logic [31:0] res_data;
    logic        cache_en;
    int          valid_cycles;
    logic [5:0]  idx;

    assign idx     = cpu_req.rdindex[9:4];
    assign cpu_res = '{data: res_data, ready: res_ready};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 1'b0;
            res_ready    <= 1'b0;
            res_data     <= '0;
            valid_cycles <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            res_ready <= 1'b0;
            if (cpu_req.valid) valid_cycles <= valid_cycles + 1;
            if (pending) begin
                pending   <= 1'b0;
                res_ready <= 1'b1;
                res_data  <= mem[idx];
                if (cpu_req.rw) begin
                    if (cpu_req.data[31:16] <= 16'd1)
                        mem[idx] <= {mem[idx][31:16], mem[idx][15:0] + cpu_req.data[15:0]};
                    else
                        mem[idx] <= cpu_req.data;
                end
            end else if (cache_en && cpu_req.valid && !res_ready) begin
                pending <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic op, input logic [CLIENT_W-1:0] cl, input logic [15:0] val,
                        output int l);
        in_op     = op;
        in_client = cl;
        in_value  = val;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 300) begin
            @(posedge clk); #1;
            l++;
        end
        chk("resp_arrives", 32'(out_valid), 32'd1);
    endtask

    task automatic expect_resp(input string tag, input logic acc, input logic [2:0] rsn,
                               input logic [CLIENT_W-1:0] cl, input logic [15:0] accum);
        chk({tag, "_accept"}, 32'(out_accept), 32'(acc));
        chk({tag, "_reason"}, 32'(out_reason), 32'(rsn));
        chk({tag, "_client"}, 32'(out_client), 32'(cl));
        chk({tag, "_accum"},  32'(out_accum),  32'(accum));
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_take", 32'(in_ready), 32'd1);
        chk("out_valid_after_take", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_client = '0;
        in_value  = '0;
        out_ready = 1'b0;
        cache_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cpu_req", 32'(cpu_req == '0), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        expect_resp("rst", 1'b0, 3'd0, 6'd0, 16'd0);

        // Limit 100 for client 3, then 60 + 40 fill it exactly, then 1 more overflows.
        send(1'b1, 6'd3, 16'd100, lat);
        expect_resp("setlim", 1'b1, 3'd0, 6'd3, 16'd0);
        take();
        send(1'b0, 6'd3, 16'd60, lat);
        expect_resp("ord60", 1'b1, 3'd0, 6'd3, 16'd60);
        chk("hit_latency_ge6", 32'(lat >= 6), 32'd1);
        take();
        send(1'b0, 6'd3, 16'd40, lat);
        expect_resp("ord40", 1'b1, 3'd0, 6'd3, 16'd100);
        take();
        send(1'b0, 6'd3, 16'd1, lat);
        expect_resp("ord1_over", 1'b0, 3'd1, 6'd3, 16'd100);
        take();

        vc_before = valid_cycles;
        send(1'b0, 6'd2, 16'd0, lat);
        expect_resp("zero_qty", 1'b0, 3'd2, 6'd2, 16'd0);
        chk("zero_qty_latency", 32'(lat), 32'd1);
        chk("zero_qty_no_cache", 32'(valid_cycles - vc_before), 32'd0);
        take();

        vc_before = valid_cycles;
        send(1'b1, 6'd3, 16'd1, lat);
        expect_resp("bad_limit", 1'b0, 3'd3, 6'd3, 16'd0);
        chk("bad_limit_latency", 32'(lat), 32'd1);
        chk("bad_limit_no_cache", 32'(valid_cycles - vc_before), 32'd0);
        take();
        send(1'b0, 6'd3, 16'd1, lat);
        expect_resp("after_bad_over", 1'b0, 3'd1, 6'd3, 16'd100);
        take();

        // Full-range limit: 65535 fits exactly, one more needs the 17th sum bit.
        send(1'b1, 6'd9, 16'hFFFF, lat);
        expect_resp("setlim_max", 1'b1, 3'd0, 6'd9, 16'd0);
        take();
        send(1'b0, 6'd9, 16'hFFFF, lat);
        expect_resp("ord_full", 1'b1, 3'd0, 6'd9, 16'hFFFF);
        take();
        send(1'b0, 6'd9, 16'd1, lat);
        expect_resp("ord_wrap_over", 1'b0, 3'd1, 6'd9, 16'hFFFF);
        take();

        // Read timeout: accept edge plus TIMEOUT waiting cycles.
        cache_en = 1'b0;
        send(1'b0, 6'd5, 16'd5, lat);
        expect_resp("timeout", 1'b0, 3'd4, 6'd5, 16'd0);
        chk("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
        chk("timeout_valid_drop", 32'(cpu_req.valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_reason", 32'(out_reason), 32'd4);
            chk("hold_client", 32'(out_client), 32'd5);
        end
        take();

`ifdef RISK_GATE_STATS_EN
        chk("stat_accept", stat_accept, 32'd5);
        chk("stat_reject", stat_reject, 32'd5);
        chk("stat_timeout", stat_timeout, 32'd1);
`endif

        // Reset while a limit write is outstanding.
        in_op     = 1'b1;
        in_client = 6'd7;
        in_value  = 16'd50;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("wr_req_valid", 32'(cpu_req.valid), 32'd1);
        chk("wr_req_rw", 32'(cpu_req.rw), 32'd1);
        chk("wr_req_data", cpu_req.data, {16'd50, 16'h0});
        chk("wr_req_index", cpu_req.rdindex, 32'h70);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cpu_req", 32'(cpu_req == '0), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        expect_resp("midrst", 1'b0, 3'd0, 6'd0, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
